// File: rtl/freqdiv_pkg.sv
// Shared types and constants for the frequency-divider reconfiguration scheduler.
// The REJECT state is only reachable when FREQDIV_RANGE_CHECK_EN is defined.
package freqdiv_pkg;

   localparam int DW_DEFAULT     = 32;
   localparam int SETTLE_DEFAULT = 4;
   localparam int DIV_MIN        = 2;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DRAIN  = 3'd1,
      LOAD   = 3'd2,
      SETTLE = 3'd3,
      RESUME = 3'd4,
      REJECT = 3'd5
   } stateT;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. It holds no state: the caller owns the
// Last pointer and only lets a grant out while Advance is high.
module rr_arb2 (
   input  logic       Req0,
   input  logic       Req1,
   input  logic       Last,
   input  logic       Advance,
   output logic [1:0] Grant,
   output logic       GrantValid
);

   always_comb begin
      Grant = 2'b00;
      if (Advance) begin
         // On contention the requester that was not served last wins.
         if (Req0 && Req1) Grant = Last ? 2'b01 : 2'b10;
         else if (Req0)    Grant = 2'b01;
         else if (Req1)    Grant = 2'b10;
      end
   end

   assign GrantValid = |Grant;

endmodule

// File: rtl/freq_div_scheduler.sv
// Shares one FrequencyDivider config port between two requesters. The divider is
// sequenced disable/settle/load/settle/resume. Define FREQDIV_RANGE_CHECK_EN to reject values below DIV_MIN.
module freq_div_scheduler
   import freqdiv_pkg::*;
#(
   parameter int DW            = DW_DEFAULT,
   parameter int SETTLE_CYCLES = SETTLE_DEFAULT
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Req0,
   input  logic          Req1,
   input  logic [DW-1:0] Div0,
   input  logic [DW-1:0] Div1,
   input  logic          RunEn,
   output logic          Ack0,
   output logic          Ack1,
   output logic [DW-1:0] DivDin,
   output logic          DivConfig,
   output logic          DivEnable,
   output logic          Busy,
   output logic [DW-1:0] CurDiv,
   output logic          Err
);

   localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

   stateT         stateReg, stateNext;
   logic [7:0]    cntReg;
   logic          lastReg, granteeReg, granteeNext;
   logic [DW-1:0] holdReg, grantDiv;
   logic          cfgValidReg, cfgValidNext;
   logic          ackNext, enableNext, rangeBad;
   logic [1:0]    grant;
   logic          grantValid;

   rr_arb2 arb (
      .Req0      (Req0),
      .Req1      (Req1),
      .Last      (lastReg),
      .Advance   (stateReg == IDLE),
      .Grant     (grant),
      .GrantValid(grantValid)
   );

   assign grantDiv = grant[1] ? Div1 : Div0;

`ifdef FREQDIV_RANGE_CHECK_EN
   localparam logic [DW-1:0] DIV_MIN_W = DW'(DIV_MIN);
   assign rangeBad = grantDiv < DIV_MIN_W;
`else
   assign rangeBad = 1'b0;
`endif

   always_comb begin
      stateNext = stateReg;
      case (stateReg)
         IDLE:    if (grantValid) stateNext = rangeBad ? REJECT : DRAIN;
         DRAIN:   if (cntReg == CNT_LAST) stateNext = LOAD;
         LOAD:    stateNext = SETTLE;
         SETTLE:  if (cntReg == CNT_LAST) stateNext = RESUME;
         RESUME:  stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Outputs are registered, so they are derived from the state being entered.
   always_comb begin
      granteeNext  = grantValid ? grant[1] : granteeReg;
      cfgValidNext = cfgValidReg | (stateReg == LOAD);
      ackNext      = (stateNext == RESUME) || (stateNext == REJECT);
      case (stateNext)
         IDLE:    enableNext = RunEn & cfgValidNext;
         RESUME:  enableNext = RunEn;
         REJECT:  enableNext = RunEn & cfgValidReg;
         default: enableNext = 1'b0;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         stateReg    <= IDLE;
         cntReg      <= '0;
         lastReg     <= 1'b1;
         granteeReg  <= 1'b0;
         holdReg     <= '0;
         cfgValidReg <= 1'b0;
         CurDiv      <= '0;
         Ack0        <= 1'b0;
         Ack1        <= 1'b0;
         DivConfig   <= 1'b0;
         DivEnable   <= 1'b0;
         Busy        <= 1'b0;
      end else begin
         stateReg <= stateNext;
         if ((stateNext == stateReg) && (stateReg == DRAIN || stateReg == SETTLE))
            cntReg <= cntReg + 8'd1;
         else
            cntReg <= '0;
         if (grantValid) begin
            holdReg    <= grantDiv;
            granteeReg <= grant[1];
            lastReg    <= grant[1];
         end
         if (stateReg == LOAD) CurDiv <= holdReg;
         cfgValidReg <= cfgValidNext;
         Ack0        <= ackNext & ~granteeNext;
         Ack1        <= ackNext & granteeNext;
         DivConfig   <= (stateNext == LOAD);
         DivEnable   <= enableNext;
         Busy        <= (stateNext != IDLE);
      end
   end

   assign DivDin = holdReg;

`ifdef FREQDIV_RANGE_CHECK_EN
   always_ff @(posedge Clk) begin
      if (!Reset) Err <= 1'b0;
      else        Err <= (stateNext == REJECT);
   end
`else
   assign Err = 1'b0;
`endif

endmodule
